axi_mem_rw_arbiter: RTL and testbench

AXI_MEM_RW_ARBITER -- requirements
Module: axi_mem_rw_arbiter

---
 rtl/axi_mem_if_pkg.sv | 30 +++
 rtl/axi_mem_rw_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_axi_mem_rw_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_if_pkg.sv
// ----------------------------------------------------------------------------
// axi_mem_if_pkg
// Shared definitions for the memory-port arbiter:
//   owner_t      - who held the SRAM port on the previous cycle (NONE/RD/WR)
//   rsp_t        - packed pair of read-response pulses (rd, wr)
//   RSP_IDLE     - no response pulse on either side
//   rsp_pulse()  - a granted access produces a response only when it is a read
//                  (CEN low, WEN high)
// ----------------------------------------------------------------------------
package axi_mem_if_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_RD   = 2'b01,
        OWN_WR   = 2'b10
    } owner_t;

    typedef struct packed {
        logic rd;
        logic wr;
    } rsp_t;

    localparam rsp_t RSP_IDLE = '{rd: 1'b0, wr: 1'b0};

    // A response is owed one cycle later only for a granted, enabled read.
    function automatic logic rsp_pulse(input logic granted, input logic cen, input logic wen);
        return granted & ~cen & wen;
    endfunction

endpackage

// File: rtl/axi_mem_rw_arbiter.sv
// ----------------------------------------------------------------------------
// axi_mem_rw_arbiter
// Shares one single-port SRAM between a read controller and a write
// controller. Grants are combinational from the valids plus the registered
// owner/run-length state; a requester may hold the port for at most MAX_RUN
// consecutive grants while the other side is waiting.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   rd_valid_i/cen/wen/a/d/be       read-controller request
//   rd_grant_o                      read controller owns the port this cycle
//   wr_valid_i/cen/wen/a/d/be       write-controller request
//   wr_grant_o                      write controller owns the port this cycle
//   MEM_CEN_o/WEN_o/A_o/D_o/BE_o    SRAM request (active-low CEN/WEN)
//   MEM_Q_i                         SRAM read data
//   rd_q_o, wr_q_o                  read data fanned out to both controllers
//   rd_rsp_o, wr_rsp_o              one-cycle pulse after a granted read
// ----------------------------------------------------------------------------
module axi_mem_rw_arbiter
    import axi_mem_if_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 64,
    parameter int NUMBYTES       = DATA_WIDTH / 8,
    parameter int MAX_RUN        = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      rd_valid_i,
    input  logic                      rd_cen_i,
    input  logic                      rd_wen_i,
    input  logic [MEM_ADDR_WIDTH-1:0] rd_a_i,
    input  logic [DATA_WIDTH-1:0]     rd_d_i,
    input  logic [NUMBYTES-1:0]       rd_be_i,
    output logic                      rd_grant_o,

    input  logic                      wr_valid_i,
    input  logic                      wr_cen_i,
    input  logic                      wr_wen_i,
    input  logic [MEM_ADDR_WIDTH-1:0] wr_a_i,
    input  logic [DATA_WIDTH-1:0]     wr_d_i,
    input  logic [NUMBYTES-1:0]       wr_be_i,
    output logic                      wr_grant_o,

    output logic                      MEM_CEN_o,
    output logic                      MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0] MEM_A_o,
    output logic [DATA_WIDTH-1:0]     MEM_D_o,
    output logic [NUMBYTES-1:0]       MEM_BE_o,
    input  logic [DATA_WIDTH-1:0]     MEM_Q_i,

    output logic [DATA_WIDTH-1:0]     rd_q_o,
    output logic [DATA_WIDTH-1:0]     wr_q_o,
    output logic                      rd_rsp_o,
    output logic                      wr_rsp_o
);

    localparam int RUN_W = (MAX_RUN < 1) ? 1 : $clog2(MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(32'd1);
    localparam logic [RUN_W-1:0] RUN_ZERO = RUN_W'(32'd0);

    owner_t           owner_r;
    logic [RUN_W-1:0] run_cnt_r;
    rsp_t             rsp_r;

    logic                      rd_gnt_s;
    logic                      wr_gnt_s;
    logic                      mem_cen_s;
    logic                      mem_wen_s;
    logic [MEM_ADDR_WIDTH-1:0] mem_a_s;
    logic [DATA_WIDTH-1:0]     mem_d_s;
    logic [NUMBYTES-1:0]       mem_be_s;

    // Run length after a grant: restart at one when ownership changes,
    // otherwise count up and stick at MAX_RUN.
    function automatic logic [RUN_W-1:0] run_next(input logic same_owner,
                                                  input logic [RUN_W-1:0] cnt);
        if (!same_owner) begin
            return RUN_ONE;
        end else if (cnt >= RUN_MAX) begin
            return RUN_MAX;
        end else begin
            return cnt + RUN_ONE;
        end
    endfunction

    // Grant decision: a lone requester always wins; under contention the
    // reader wins from idle, the owner keeps the port until its run is used
    // up, then the port hands over without a bubble.
    always_comb begin
        rd_gnt_s = 1'b0;
        wr_gnt_s = 1'b0;
        case ({rd_valid_i, wr_valid_i})
            2'b10: rd_gnt_s = 1'b1;
            2'b01: wr_gnt_s = 1'b1;
            2'b11: begin
                case (owner_r)
                    OWN_RD: begin
                        if (run_cnt_r < RUN_MAX) begin
                            rd_gnt_s = 1'b1;
                        end else begin
                            wr_gnt_s = 1'b1;
                        end
                    end
                    OWN_WR: begin
                        if (run_cnt_r < RUN_MAX) begin
                            wr_gnt_s = 1'b1;
                        end else begin
                            rd_gnt_s = 1'b1;
                        end
                    end
                    default: rd_gnt_s = 1'b1;
                endcase
            end
            default: begin
                rd_gnt_s = 1'b0;
                wr_gnt_s = 1'b0;
            end
        endcase
    end

    // SRAM request mux: the granted side drives the port, otherwise the port
    // is parked disabled with zeroed address/data/byte-enables.
    always_comb begin
        mem_cen_s = 1'b1;
        mem_wen_s = 1'b1;
        mem_a_s   = {MEM_ADDR_WIDTH{1'b0}};
        mem_d_s   = {DATA_WIDTH{1'b0}};
        mem_be_s  = {NUMBYTES{1'b0}};
        if (rd_gnt_s) begin
            mem_cen_s = rd_cen_i;
            mem_wen_s = rd_wen_i;
            mem_a_s   = rd_a_i;
            mem_d_s   = rd_d_i;
            mem_be_s  = rd_be_i;
        end else if (wr_gnt_s) begin
            mem_cen_s = wr_cen_i;
            mem_wen_s = wr_wen_i;
            mem_a_s   = wr_a_i;
            mem_d_s   = wr_d_i;
            mem_be_s  = wr_be_i;
        end else begin
            mem_cen_s = 1'b1;
            mem_wen_s = 1'b1;
            mem_a_s   = {MEM_ADDR_WIDTH{1'b0}};
            mem_d_s   = {DATA_WIDTH{1'b0}};
            mem_be_s  = {NUMBYTES{1'b0}};
        end
    end

    // Ownership FSM, run-length counter and response pulses. Reset clears the
    // response register, so a read in flight at reset never reports back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r   <= OWN_NONE;
            run_cnt_r <= RUN_ZERO;
            rsp_r     <= RSP_IDLE;
        end else begin
            rsp_r <= '{rd: rsp_pulse(rd_gnt_s, rd_cen_i, rd_wen_i),
                       wr: rsp_pulse(wr_gnt_s, wr_cen_i, wr_wen_i)};
            case (owner_r)
                OWN_NONE, OWN_RD, OWN_WR: begin
                    if (rd_gnt_s) begin
                        owner_r   <= OWN_RD;
                        run_cnt_r <= run_next(owner_r == OWN_RD, run_cnt_r);
                    end else if (wr_gnt_s) begin
                        owner_r   <= OWN_WR;
                        run_cnt_r <= run_next(owner_r == OWN_WR, run_cnt_r);
                    end else begin
                        owner_r   <= OWN_NONE;
                        run_cnt_r <= RUN_ZERO;
                    end
                end
                default: begin
                    owner_r   <= OWN_NONE;
                    run_cnt_r <= RUN_ZERO;
                end
            endcase
        end
    end

    assign rd_grant_o = rd_gnt_s;
    assign wr_grant_o = wr_gnt_s;
    assign MEM_CEN_o  = mem_cen_s;
    assign MEM_WEN_o  = mem_wen_s;
    assign MEM_A_o    = mem_a_s;
    assign MEM_D_o    = mem_d_s;
    assign MEM_BE_o   = mem_be_s;
    assign rd_q_o     = MEM_Q_i;
    assign wr_q_o     = MEM_Q_i;
    assign rd_rsp_o   = rsp_r.rd;
    assign wr_rsp_o   = rsp_r.wr;

endmodule

// File: tb/tb_axi_mem_rw_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_mem_rw_arbiter
// Directed scenarios plus a randomized run, all checked against a small
// rule-level model of the arbiter (who should win, how long a run lasts,
// which granted accesses owe a response).
// ----------------------------------------------------------------------------
module tb_axi_mem_rw_arbiter;
    import axi_mem_if_pkg::*;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int MAXR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_valid, rd_cen, rd_wen, wr_valid, wr_cen, wr_wen;
    logic [AW-1:0] rd_a, wr_a;
    logic [DW-1:0] rd_d, wr_d, mem_q;
    logic [BW-1:0] rd_be, wr_be;
    logic          rd_grant, wr_grant, mem_cen, mem_wen, rd_rsp, wr_rsp;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d, rd_q, wr_q;
    logic [BW-1:0] mem_be;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: owner 0=none 1=rd 2=wr, run length, pending responses
    int m_owner;
    int m_run;
    bit m_rd_rsp;
    bit m_wr_rsp;

    always #5 clk = ~clk;

    axi_mem_rw_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUMBYTES(BW), .MAX_RUN(MAXR)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_valid_i(rd_valid), .rd_cen_i(rd_cen), .rd_wen_i(rd_wen), .rd_a_i(rd_a),
        .rd_d_i(rd_d), .rd_be_i(rd_be), .rd_grant_o(rd_grant),
        .wr_valid_i(wr_valid), .wr_cen_i(wr_cen), .wr_wen_i(wr_wen), .wr_a_i(wr_a),
        .wr_d_i(wr_d), .wr_be_i(wr_be), .wr_grant_o(wr_grant),
        .MEM_CEN_o(mem_cen), .MEM_WEN_o(mem_wen), .MEM_A_o(mem_a), .MEM_D_o(mem_d),
        .MEM_BE_o(mem_be), .MEM_Q_i(mem_q),
        .rd_q_o(rd_q), .wr_q_o(wr_q), .rd_rsp_o(rd_rsp), .wr_rsp_o(wr_rsp)
    );

    // Expected {rd_grant, wr_grant} from the arbitration rules.
    function automatic logic [1:0] model_grant();
        if (!rd_valid && !wr_valid) return 2'b00;
        if (rd_valid && !wr_valid) return 2'b10;
        if (wr_valid && !rd_valid) return 2'b01;
        if (m_owner == 0) return 2'b10;
        if (m_run < MAXR) return (m_owner == 1) ? 2'b10 : 2'b01;
        return (m_owner == 1) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_run = 0; m_rd_rsp = 1'b0; m_wr_rsp = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs.
    task automatic model_commit();
        logic [1:0] g;
        int nxt;
        g = model_grant();
        m_rd_rsp = g[1] && !rd_cen && rd_wen;
        m_wr_rsp = g[0] && !wr_cen && wr_wen;
        if (g == 2'b00) begin
            m_owner = 0; m_run = 0;
        end else begin
            nxt = g[1] ? 1 : 2;
            if (nxt == m_owner) m_run = (m_run >= MAXR) ? MAXR : m_run + 1;
            else m_run = 1;
            m_owner = nxt;
        end
    endtask

    task automatic set_idle();
        rd_valid = 1'b0; rd_cen = 1'b1; rd_wen = 1'b1; rd_a = '0; rd_d = '0; rd_be = '0;
        wr_valid = 1'b0; wr_cen = 1'b1; wr_wen = 1'b1; wr_a = '0; wr_d = '0; wr_be = '0;
    endtask

    task automatic next_cycle();
        model_commit();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; set_idle(); mem_q = '0; model_reset();
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({rd_grant, wr_grant, mem_cen, mem_wen, rd_rsp, wr_rsp} !== 6'b001100) $display("FAIL reset_outputs got %b exp 001100", {rd_grant, wr_grant, mem_cen, mem_wen, rd_rsp, wr_rsp});
        else n_pass++;
        n_checks++;
        if (dut.owner_r !== OWN_NONE || int'(dut.run_cnt_r) != 0) $display("FAIL reset_state got owner %0d run %0d exp 0 0", dut.owner_r, dut.run_cnt_r);
        else n_pass++;
        rd_valid = 1'b1; rd_cen = 1'b0;
        #1;
        n_checks++;
        if (rd_grant !== 1'b1 || wr_grant !== 1'b0) $display("FAIL reset_comb_grant got %b%b exp 10", rd_grant, wr_grant);
        else n_pass++;
        @(posedge clk); #1;
        set_idle(); rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rd_rsp !== 1'b0) $display("FAIL reset_no_rsp got %b exp 0", rd_rsp);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_rd_only();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            if (i < 3) begin rd_valid = 1'b1; rd_cen = 1'b0; rd_wen = 1'b1; rd_a = AW'(16 + i); end
            @(negedge clk);
            n_checks++;
            if (rd_rsp !== (i > 0)) $display("FAIL rd_only_rsp[%0d] got %b exp %b", i, rd_rsp, i > 0);
            else n_pass++;
            if (i < 3) begin
                n_checks++;
                if (rd_grant !== 1'b1 || wr_grant !== 1'b0 || mem_a !== AW'(16 + i) || mem_cen !== 1'b0)
                    $display("FAIL rd_only_grant[%0d] got g=%b a=%h cen=%b exp g=1 a=%h cen=0", i, rd_grant, mem_a, mem_cen, AW'(16 + i));
                else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_no_valid();
        set_idle();
        @(negedge clk);
        n_checks++;
        if (mem_cen !== 1'b1 || mem_wen !== 1'b1 || mem_a !== '0 || mem_d !== '0 || mem_be !== '0 || rd_grant !== 1'b0 || wr_grant !== 1'b0)
            $display("FAIL no_valid got cen=%b wen=%b a=%h g=%b%b exp cen=1 wen=1 a=0 g=00", mem_cen, mem_wen, mem_a, rd_grant, wr_grant);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_write();
        set_idle();
        wr_valid = 1'b1; wr_cen = 1'b0; wr_wen = 1'b0; wr_be = 8'hFF; wr_d = 64'hDEADBEEF; wr_a = 13'h0A5;
        @(negedge clk);
        n_checks++;
        if (wr_grant !== 1'b1 || rd_grant !== 1'b0 || mem_wen !== 1'b0 || mem_cen !== 1'b0 || mem_d !== 64'hDEADBEEF || mem_be !== 8'hFF || mem_a !== 13'h0A5)
            $display("FAIL write_pass got g=%b%b wen=%b d=%h be=%h exp g=01 wen=0 d=deadbeef be=ff", rd_grant, wr_grant, mem_wen, mem_d, mem_be);
        else n_pass++;
        next_cycle();
        set_idle();
        @(negedge clk);
        n_checks++;
        if (wr_rsp !== 1'b0 || rd_rsp !== 1'b0) $display("FAIL write_no_rsp got %b%b exp 00", rd_rsp, wr_rsp);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0; set_idle(); model_reset();
        @(posedge clk); #1;
        rd_valid = 1'b1; rd_cen = 1'b0; rd_wen = 1'b1;
        wr_valid = 1'b1; wr_cen = 1'b0; wr_wen = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [1:0] exp_g;
            exp_g = (i < 4 || i >= 8) ? 2'b10 : 2'b01;
            rd_a = AW'(i); wr_a = AW'(100 + i);
            @(negedge clk);
            n_checks++;
            if ({rd_grant, wr_grant} !== exp_g) $display("FAIL b2b_grant[%0d] got %b exp %b", i, {rd_grant, wr_grant}, exp_g);
            else n_pass++;
            next_cycle();
        end
        set_idle();
        next_cycle();
    endtask

    task automatic test_owner_drop();
        set_idle();
        next_cycle();
        rd_valid = 1'b1; rd_cen = 1'b0; rd_wen = 1'b1;
        next_cycle();
        next_cycle();
        set_idle();
        @(negedge clk);
        n_checks++;
        if (dut.owner_r !== OWN_RD || int'(dut.run_cnt_r) != 2) $display("FAIL drop_pre got owner %0d run %0d exp 1 2", dut.owner_r, dut.run_cnt_r);
        else n_pass++;
        next_cycle();
        rd_valid = 1'b1; rd_cen = 1'b0; rd_wen = 1'b1; wr_valid = 1'b1; wr_cen = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.owner_r !== OWN_NONE || rd_grant !== 1'b1 || wr_grant !== 1'b0)
            $display("FAIL drop_regrant got owner %0d g=%b%b exp 0 g=10", dut.owner_r, rd_grant, wr_grant);
        else n_pass++;
        next_cycle();
        set_idle();
        @(negedge clk);
        n_checks++;
        if (dut.owner_r !== OWN_RD || int'(dut.run_cnt_r) != 1) $display("FAIL drop_post got owner %0d run %0d exp 1 1", dut.owner_r, dut.run_cnt_r);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_midrun();
        set_idle();
        rd_valid = 1'b1; rd_cen = 1'b0; rd_wen = 1'b1; rd_a = 13'h055;
        @(negedge clk);
        n_checks++;
        if (rd_grant !== 1'b1) $display("FAIL midrun_grant got %b exp 1", rd_grant);
        else n_pass++;
        #1 rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        set_idle(); rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (rd_rsp !== 1'b0 || dut.owner_r !== OWN_NONE) $display("FAIL midrun_after[%0d] got rsp %b owner %0d exp 0 0", i, rd_rsp, dut.owner_r);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [1:0] g;
            logic       exp_cen, exp_wen;
            logic [AW-1:0] exp_a;
            rd_valid = ($urandom_range(3) != 0); wr_valid = ($urandom_range(3) != 0);
            rd_cen = ($urandom_range(7) == 0); rd_wen = ($urandom_range(7) != 0);
            wr_cen = ($urandom_range(7) == 0); wr_wen = ($urandom_range(3) == 0);
            rd_a = AW'($urandom); wr_a = AW'($urandom);
            rd_d = {$urandom, $urandom}; wr_d = {$urandom, $urandom};
            rd_be = BW'($urandom); wr_be = BW'($urandom);
            mem_q = {$urandom, $urandom};
            g = model_grant();
            exp_cen = g[1] ? rd_cen : (g[0] ? wr_cen : 1'b1);
            exp_wen = g[1] ? rd_wen : (g[0] ? wr_wen : 1'b1);
            exp_a   = g[1] ? rd_a : (g[0] ? wr_a : '0);
            @(negedge clk);
            n_checks++;
            if ({rd_grant, wr_grant} !== g) $display("FAIL rand_grant[%0d] got %b exp %b", i, {rd_grant, wr_grant}, g);
            else n_pass++;
            n_checks++;
            if ({mem_cen, mem_wen, mem_a} !== {exp_cen, exp_wen, exp_a})
                $display("FAIL rand_mem[%0d] got cen=%b wen=%b a=%h exp cen=%b wen=%b a=%h", i, mem_cen, mem_wen, mem_a, exp_cen, exp_wen, exp_a);
            else n_pass++;
            n_checks++;
            if ({rd_rsp, wr_rsp} !== {m_rd_rsp, m_wr_rsp}) $display("FAIL rand_rsp[%0d] got %b%b exp %b%b", i, rd_rsp, wr_rsp, m_rd_rsp, m_wr_rsp);
            else n_pass++;
            n_checks++;
            if (rd_q !== mem_q || wr_q !== mem_q) $display("FAIL rand_q[%0d] got %h/%h exp %h", i, rd_q, wr_q, mem_q);
            else n_pass++;
            next_cycle();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_rd_only();
        test_no_valid();
        test_write();
        test_back_to_back();
        test_owner_drop();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
